// File: rtl/prco_lmem_pipe.sv
// PRCO local-memory pipeline stage: one synchronous read or byte-masked write
// per accepted operation, a registered read result, and a range fault flag.
// The stage sits between execute and writeback and uses the core's
// valid/stall/ce handshake. The output registers hold while downstream stalls.
module prco_lmem_pipe #(
   parameter int P_DATA_W    = 16,
   parameter int P_ADDR_W    = 8,
   parameter int P_DEPTH     = 256,
   parameter int P_INIT_ZERO = 1
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_p_cp,
   input  logic                  i_p_valid,
   input  logic                  i_p_stalled,
   output logic                  q_p_stalled,
   output logic                  q_p_ce,
   output logic                  q_p_valid,
   input  logic                  i_mem_we,
   input  logic [P_DATA_W/8-1:0] i_mem_be,
   input  logic [P_ADDR_W-1:0]   i_mem_addr,
   input  logic [P_DATA_W-1:0]   i_mem_dina,
   output logic [P_DATA_W-1:0]   q_mem_douta,
   output logic                  q_fault
);

   localparam int LP_NB = P_DATA_W / 8;
   // P_DEPTH <= 2**P_ADDR_W, so one extra bit is enough to hold it.
   localparam logic [P_ADDR_W:0]   LP_DEPTH = (P_ADDR_W + 1)'(P_DEPTH);
   localparam logic [P_DATA_W-1:0] LP_INIT  = (P_INIT_ZERO != 0) ? '0 : 'x;

   // Power-up contents only; reset never touches the array.
   logic [P_DATA_W-1:0] mem_q [P_DEPTH] = '{default: LP_INIT};

   logic                valid_q, valid_d;
   logic                fault_q, fault_d;
   logic [P_DATA_W-1:0] douta_q, douta_d;
   logic                in_range;
   logic [P_DATA_W-1:0] rd_data;

   assign q_p_stalled = valid_q & i_p_stalled;
   assign q_p_ce      = i_p_valid & ~q_p_stalled & ~i_p_cp & ~i_reset;
   assign in_range    = ({1'b0, i_mem_addr} < LP_DEPTH);
   // The index is guarded so that an out-of-range address never reads the array.
   assign rd_data     = in_range ? mem_q[i_mem_addr] : '0;

   assign q_p_valid   = valid_q;
   assign q_fault     = fault_q;
   assign q_mem_douta = douta_q;

   // Next-state for the output registers: reset/flush > accept > stall hold > drain
   always_comb begin
      valid_d = valid_q;
      fault_d = fault_q;
      douta_d = douta_q;
      if (i_reset || i_p_cp) begin
         valid_d = 1'b0;
         fault_d = 1'b0;
         douta_d = '0;
      end else if (q_p_ce) begin
         valid_d = 1'b1;
         fault_d = ~in_range;
         douta_d = rd_data;
      end else if (q_p_stalled) begin
         valid_d = valid_q;
      end else begin
         valid_d = 1'b0;
      end
   end

   // Output registers; the synchronous reset is folded into the next-state logic
   always_ff @(posedge i_clk) begin
      valid_q <= valid_d;
      fault_q <= fault_d;
      douta_q <= douta_d;
   end

   // Byte-masked write. The read above sees the old word (read-first), and
   // an out-of-range write is silently dropped.
   always_ff @(posedge i_clk) begin
      if (q_p_ce && i_mem_we && in_range) begin
         for (int k = 0; k < LP_NB; k++) begin
            if (i_mem_be[k]) begin
               mem_q[i_mem_addr][8*k +: 8] <= i_mem_dina[8*k +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_prco_lmem_pipe.sv
// Directed bench for prco_lmem_pipe (9-bit address, 300 words). Expected results
// come from a behavioural memory model and pass through a scoreboard queue.
module tb_prco_lmem_pipe;

   localparam int DW = 16;
   localparam int AW = 9;
   localparam int DEPTH = 300;

   logic          i_clk = 1'b0;
   logic          i_reset = 1'b1;
   logic          i_p_cp = 1'b0;
   logic          i_p_valid = 1'b0;
   logic          i_p_stalled = 1'b0;
   logic          q_p_stalled;
   logic          q_p_ce;
   logic          q_p_valid;
   logic          i_mem_we = 1'b0;
   logic [1:0]    i_mem_be = 2'b00;
   logic [AW-1:0] i_mem_addr = '0;
   logic [DW-1:0] i_mem_dina = '0;
   logic [DW-1:0] q_mem_douta;
   logic          q_fault;

   prco_lmem_pipe #(
      .P_DATA_W(DW), .P_ADDR_W(AW), .P_DEPTH(DEPTH), .P_INIT_ZERO(1)
   ) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_p_cp(i_p_cp),
      .i_p_valid(i_p_valid), .i_p_stalled(i_p_stalled),
      .q_p_stalled(q_p_stalled), .q_p_ce(q_p_ce), .q_p_valid(q_p_valid),
      .i_mem_we(i_mem_we), .i_mem_be(i_mem_be), .i_mem_addr(i_mem_addr),
      .i_mem_dina(i_mem_dina), .q_mem_douta(q_mem_douta), .q_fault(q_fault)
   );

   always #5 i_clk = ~i_clk;

   typedef struct packed {
      logic [DW-1:0] d;
      logic          f;
   } exp_t;

   exp_t          sbq[$];
   logic [DW-1:0] m [DEPTH];
   logic          exp_valid = 1'b0;
   logic [DW-1:0] exp_douta = '0;
   logic          exp_fault = 1'b0;
   int            checks = 0;
   int            failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, check handshake before the edge, then
   // check the registered outputs after it.
   task automatic issue(input logic v_, input logic we_, input logic [1:0] be_,
                        input logic [AW-1:0] a_, input logic [DW-1:0] d_,
                        input logic st_, input logic cp_, input logic rs_,
                        input string tag);
      logic ce_;
      logic st_exp;
      exp_t e;
      i_p_valid   = v_;
      i_mem_we    = we_;
      i_mem_be    = be_;
      i_mem_addr  = a_;
      i_mem_dina  = d_;
      i_p_stalled = st_;
      i_p_cp      = cp_;
      i_reset     = rs_;
      #3;
      st_exp = exp_valid & st_;
      ce_    = v_ & ~st_exp & ~cp_ & ~rs_;
      chk({tag, ".stalled"}, {31'd0, q_p_stalled}, {31'd0, st_exp});
      chk({tag, ".ce"}, {31'd0, q_p_ce}, {31'd0, ce_});
      if (rs_ || cp_) begin
         exp_valid = 1'b0;
         exp_douta = '0;
         exp_fault = 1'b0;
      end else if (ce_) begin
         e.d = (int'(a_) < DEPTH) ? m[a_] : '0;
         e.f = (int'(a_) >= DEPTH);
         sbq.push_back(e);
         if (we_ && int'(a_) < DEPTH) begin
            for (int k = 0; k < 2; k++)
               if (be_[k]) m[a_][8*k +: 8] = d_[8*k +: 8];
         end
         exp_valid = 1'b1;
      end else if (!st_exp) begin
         exp_valid = 1'b0;
      end
      @(posedge i_clk);
      #1;
      if (ce_) begin
         e = sbq.pop_front();
         exp_douta = e.d;
         exp_fault = e.f;
      end
      chk({tag, ".valid"}, {31'd0, q_p_valid}, {31'd0, exp_valid});
      chk({tag, ".douta"}, {16'd0, q_mem_douta}, {16'd0, exp_douta});
      chk({tag, ".fault"}, {31'd0, q_fault}, {31'd0, exp_fault});
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) m[i] = '0;

      // Reset and first read of a zero-initialised word
      issue(0, 0, 2'b00, 9'd0, 16'h0000, 0, 0, 1, "rst0");
      issue(0, 0, 2'b00, 9'd0, 16'h0000, 0, 0, 1, "rst1");
      issue(0, 0, 2'b00, 9'd0, 16'h0000, 0, 0, 0, "idle");
      issue(1, 0, 2'b00, 9'd0, 16'h0000, 0, 0, 0, "rd0");
      chk("rd0.abs", {16'd0, q_mem_douta}, 32'h0000);

      // Full write then read-back; the write returns the old contents
      issue(1, 1, 2'b11, 9'd5, 16'h20AB, 0, 0, 0, "wr5");
      chk("wr5.old", {16'd0, q_mem_douta}, 32'h0000);
      issue(1, 0, 2'b00, 9'd5, 16'h0000, 0, 0, 0, "rd5a");
      chk("rd5a.abs", {16'd0, q_mem_douta}, 32'h20AB);

      // Low-byte-only write
      issue(1, 1, 2'b01, 9'd5, 16'hFFFF, 0, 0, 0, "wr5be");
      issue(1, 0, 2'b00, 9'd5, 16'h0000, 0, 0, 0, "rd5b");
      chk("rd5b.abs", {16'd0, q_mem_douta}, 32'h20FF);

      // A write with no byte enables changes nothing but still yields a result
      issue(1, 1, 2'b00, 9'd5, 16'h1111, 0, 0, 0, "wr5be0");
      issue(1, 0, 2'b00, 9'd5, 16'h0000, 0, 0, 0, "rd5c");

      // Downstream stall holds outputs; the op is accepted once released
      issue(1, 1, 2'b11, 9'd6, 16'hA5A5, 1, 0, 0, "stall0");
      issue(1, 1, 2'b11, 9'd6, 16'hA5A5, 1, 0, 0, "stall1");
      issue(1, 1, 2'b11, 9'd6, 16'hA5A5, 0, 0, 0, "release");
      issue(1, 0, 2'b00, 9'd6, 16'h0000, 0, 0, 0, "rd6");
      chk("rd6.abs", {16'd0, q_mem_douta}, 32'hA5A5);

      // Drain: no new op, so valid drops while the data holds
      issue(0, 0, 2'b00, 9'd0, 16'h0000, 0, 0, 0, "drain");

      // Out-of-range write faults and does not alias onto addr 100
      issue(1, 1, 2'b11, 9'd100, 16'hBEEF, 0, 0, 0, "wr100");
      issue(1, 1, 2'b11, 9'd400, 16'h1234, 0, 0, 0, "wr400");
      chk("wr400.fault", {31'd0, q_fault}, 32'd1);
      issue(1, 0, 2'b00, 9'd100, 16'h0000, 0, 0, 0, "rd100");
      chk("rd100.abs", {16'd0, q_mem_douta}, 32'hBEEF);
      issue(1, 0, 2'b00, 9'd299, 16'h0000, 0, 0, 0, "rd299");
      issue(1, 0, 2'b00, 9'd300, 16'h0000, 0, 0, 0, "rd300");

      // Flush suppresses a concurrent write
      issue(1, 1, 2'b11, 9'd7, 16'h0777, 0, 0, 0, "wr7");
      issue(1, 1, 2'b11, 9'd7, 16'h5555, 0, 1, 0, "flush");
      issue(1, 0, 2'b00, 9'd7, 16'h0000, 0, 0, 0, "rd7");
      chk("rd7.abs", {16'd0, q_mem_douta}, 32'h0777);

      // Reset in the middle of a stall clears valid, which releases the stall
      issue(1, 0, 2'b00, 9'd5, 16'h0000, 1, 0, 0, "mstall0");
      issue(1, 0, 2'b00, 9'd5, 16'h0000, 1, 0, 1, "mrst");
      issue(0, 0, 2'b00, 9'd0, 16'h0000, 1, 0, 0, "postrst");
      chk("postrst.stalled", {31'd0, q_p_stalled}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
